// File: rtl/stream_topk_sorter.sv
// Streaming top-K sorter: keeps the DEPTH best keys of a frame in a sorted
// register array (single-cycle insertion) and emits them in order on tlast.
module stream_topk_sorter #(
    parameter int C_S_AXI_TDATA_WIDTH = 16,
    parameter int C_M_AXI_TDATA_WIDTH = 16,
    parameter int KEY_WIDTH           = 8,
    parameter int DEPTH               = 8,
    parameter bit DESCEND             = 1'b0
) (
    input  logic                               aclk,
    input  logic                               s_axi_aresetn,
    input  logic                               s_axi_tvalid,
    output logic                               s_axi_tready,
    input  logic [C_S_AXI_TDATA_WIDTH-1:0]     s_axi_tdata,
    input  logic [C_S_AXI_TDATA_WIDTH/8-1:0]   s_axi_tkeep,
    input  logic                               s_axi_tlast,
    output logic                               m_axi_tvalid,
    input  logic                               m_axi_tready,
    output logic [C_M_AXI_TDATA_WIDTH-1:0]     m_axi_tdata,
    output logic [C_M_AXI_TDATA_WIDTH/8-1:0]   m_axi_tkeep,
    output logic                               m_axi_tlast,
    output logic [$clog2(DEPTH+1)-1:0]         occupancy
);

    localparam int DW    = C_M_AXI_TDATA_WIDTH;
    localparam int OCC_W = $clog2(DEPTH+1);
    localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    data_q [DEPTH];
    logic [DW-1:0]    data_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             rdy_q;
    logic [DEPTH-1:0] ins;
    logic             in_hs, out_hs;
    logic             unused_tkeep;

    function automatic logic better(input logic [KEY_WIDTH-1:0] a, input logic [KEY_WIDTH-1:0] b);
        return DESCEND ? (a > b) : (a < b);
    endfunction

    assign unused_tkeep = ^s_axi_tkeep;

    assign s_axi_tready = rdy_q && (state_q == FILL);
    assign m_axi_tvalid = (state_q == DRAIN);
    assign m_axi_tdata  = (state_q == DRAIN) ? data_q[0] : '0;
    assign m_axi_tlast  = (state_q == DRAIN) && (occ_q == OCC_W'(1));
    assign m_axi_tkeep  = '1;
    assign occupancy    = occ_q;

    assign in_hs  = s_axi_tvalid && s_axi_tready;
    assign out_hs = m_axi_tvalid && m_axi_tready;

    // Array is packed and sorted, so the insert mask is a thermometer: the new
    // beat lands at its lowest set bit; equal keys do not set it (stable ties).
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            ins[i] = !vld_q[i] || better(s_axi_tdata[KEY_WIDTH-1:0], data_q[i][KEY_WIDTH-1:0]);
    end

    always_comb begin
        // NOTE: every next-state signal gets its default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        vld_d   = vld_q;
        occ_d   = occ_q;
        for (int i = 0; i < DEPTH; i++)
            data_d[i] = data_q[i];

        if (in_hs) begin
            if (ins[DEPTH-1]) begin
                if (ins[0]) begin
                    data_d[0] = s_axi_tdata;
                    vld_d[0]  = 1'b1;
                end
                for (int i = 1; i < DEPTH; i++) begin
                    if (ins[i] && !ins[i-1]) begin
                        data_d[i] = s_axi_tdata;
                        vld_d[i]  = 1'b1;
                    end else if (ins[i]) begin
                        data_d[i] = data_q[i-1];
                        vld_d[i]  = vld_q[i-1];
                    end
                end
            end
            if (occ_q != FULL)
                occ_d = occ_q + OCC_W'(1);
            if (s_axi_tlast)
                state_d = DRAIN;
        end else if (out_hs) begin
            for (int i = 0; i < DEPTH-1; i++)
                data_d[i] = data_q[i+1];
            data_d[DEPTH-1] = '0;
            vld_d = vld_q >> 1;
            occ_d = occ_q - OCC_W'(1);
            if (occ_q == OCC_W'(1))
                state_d = FILL;
        end
    end

    always_ff @(posedge aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q <= FILL;
            vld_q   <= '0;
            occ_q   <= '0;
            rdy_q   <= 1'b0;
            // NOTE: the slot array is reset too, so a reset mid-drain can never leak stale entries onto m_axi_tdata.
            for (int i = 0; i < DEPTH; i++)
                data_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments so every slot samples the pre-edge array during the shift.
            state_q <= state_d;
            vld_q   <= vld_d;
            occ_q   <= occ_d;
            rdy_q   <= 1'b1;
            for (int i = 0; i < DEPTH; i++)
                data_q[i] <= data_d[i];
        end
    end

endmodule

// File: doc/stream_topk_sorter.md
Name: stream_topk_sorter

Overview:
- Parametrised AXI-Stream top-K sorter for the heap_sort IP path, generalising the fixed 16-bit/8-bit-key register stage.
- Accepts a frame of key/payload beats and keeps the DEPTH best keys in a sorted register array using single-cycle insertion.
- On tlast, streams the retained entries out in sorted order.
- Sort direction is selectable by parameter.

Parameters:
- C_S_AXI_TDATA_WIDTH, 16, input beat width; must equal C_M_AXI_TDATA_WIDTH.
- C_M_AXI_TDATA_WIDTH, 16, output beat width.
- KEY_WIDTH, 8, sort key is tdata[KEY_WIDTH-1:0]; upper bits are payload carried with the key, never compared.
- DEPTH, 8, number of retained entries (K); legal range 2..64.
- DESCEND, 0, 0 keeps and emits smallest keys first; 1 keeps and emits largest keys first.

Ports:
- aclk  in  1  clock
- s_axi_aresetn  in  1  asynchronous active-low reset; resets the whole block
- s_axi_tvalid  in  1  input beat valid
- s_axi_tready  out  1  input ready
- s_axi_tdata  in  C_S_AXI_TDATA_WIDTH  key (LSBs) + payload
- s_axi_tkeep  in  C_S_AXI_TDATA_WIDTH/8  ignored; all bytes treated valid
- s_axi_tlast  in  1  last beat of frame
- m_axi_tvalid  out  1  output beat valid
- m_axi_tready  in  1  output ready
- m_axi_tdata  out  C_M_AXI_TDATA_WIDTH  sorted entry
- m_axi_tkeep  out  C_M_AXI_TDATA_WIDTH/8  constant all ones
- m_axi_tlast  out  1  last sorted entry of frame
- occupancy  out  $clog2(DEPTH+1)  valid entries currently held

Behaviour:
- Reset (asynchronous, any time, including mid-frame or mid-drain):
  - slot array cleared; occupancy=0; state=FILL.
  - s_axi_tready=0 while reset is asserted, 1 from the first clock edge after release.
  - m_axi_tvalid=0, m_axi_tlast=0, m_axi_tdata=0.
  - m_axi_tkeep is all ones regardless of reset.
- Storage: slots 0..DEPTH-1, each holding a full tdata word plus a valid bit. Slot 0 holds the best entry.
- "Better" means key less than (DESCEND=0) or key greater than (DESCEND=1), compared unsigned.
- FILL state:
  - s_axi_tready=1, m_axi_tvalid=0.
  - Each accepted beat (tvalid&&tready) is inserted in the same cycle: every slot compares in parallel; the new entry goes at the first position whose key is strictly worse; worse entries shift down one slot.
  - Ties: new entry is placed after all existing equal keys (stable, arrival order kept).
  - occupancy < DEPTH: occupancy increments.
  - occupancy == DEPTH: the slot-(DEPTH-1) entry is discarded and occupancy stays at DEPTH. If the new key is not strictly better than slot DEPTH-1, the new beat is dropped and the array is unchanged.
  - An accepted beat with tlast=1 is inserted as above; the next state is DRAIN.
  - Beats with tvalid=0 have no effect.
- DRAIN state:
  - s_axi_tready=0.
  - m_axi_tvalid=1 from the cycle after the tlast beat is accepted (latency 1 clock).
  - m_axi_tdata = slot 0; m_axi_tlast = (occupancy==1).
  - On m_axi_tready: the array shifts up one slot and occupancy decrements. The next entry is presented in the following cycle with no bubble.
  - While m_axi_tvalid && !m_axi_tready, tdata and tlast are held stable.
  - On acceptance of the tlast beat: m_axi_tvalid=0 and state=FILL in the next cycle; the array is then empty.
- A drained frame always contains min(frame length, DEPTH) beats. A frame is never empty, because the tlast beat itself is inserted.
- Back-to-back frames: input is stalled (tready=0) for the whole drain. The next frame's first beat is accepted the cycle after the final output handshake.
- Simultaneous events: an input handshake and an output handshake can never occur in the same cycle, because the states are exclusive.
- occupancy is registered and reflects the array after the most recent edge.

Test Plan:
- DEPTH=4, DESCEND=0: frame keys 9,3,7,1,5 (tlast on 5) → m_axi_tdata 1,3,5,7; tlast only on 7; first output valid 1 clock after the tlast beat.
- DEPTH=4, DESCEND=1: same frame → output 9,7,5,3; key 1 dropped; occupancy reads 4 after the fifth beat.
- Ties, DEPTH=4: beats 0x0105,0x0205,0x0303 (tlast) → output 0x0303,0x0105,0x0205 (payload order preserved); occupancy ends at 3.
- Backpressure: toggle m_axi_tready 1,0,0,1 during drain → tdata and tlast held stable while stalled; no beat lost or duplicated; s_axi_tready=0 throughout the drain.
- Single-beat frame: key 0x42 with tlast → one output beat 0x42, tlast=1; s_axi_tready returns to 1 one cycle after the handshake.
- Reset mid-drain: assert s_axi_aresetn=0 after 2 of 4 outputs → m_axi_tvalid=0 and occupancy=0 immediately, without waiting for a clock edge; the next frame sorts correctly with no stale entries.
